inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 32'h1c00_0000, giving the first fetch address after reset.
REQ-002 The block SHALL take parameter DEPTH, default 4, giving the number of instruction-queue entries; it is a power of two, at least 2.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 redirect_valid  input  1  branch/jump taken this cycle.
REQ-006 redirect_pc  input  32  redirect target.
REQ-007 icache_addr  output  32  fetch address to the instruction cache; combinational copy of the fetch PC.
REQ-008 icache_inst  input  32  instruction word returned for icache_addr in the same cycle.
REQ-009 icache_ready  input  1  icache_inst is valid this cycle.
REQ-010 id_valid  output  1  queue head holds a valid instruction.
REQ-011 id_pc  output  32  PC of the queue head.
REQ-012 id_inst  output  32  instruction at the queue head.
REQ-013 id_ready  input  1  decode accepts the head this cycle.

Function
REQ-014 The fetch PC SHALL be a 32-bit register, always word aligned, with bits [1:0] forced to 0.
REQ-015 A push SHALL occur when icache_ready=1, redirect_valid=0, and either count<DEPTH or a pop occurs in the same cycle.
- A push writes {fetch PC, icache_inst} at the tail.
- A push advances the fetch PC by 4, with modulo-2^32 wrap-around (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-016 A pop SHALL occur when id_valid=1 and id_ready=1; it advances the head.
REQ-017 Without a push, the fetch PC SHALL hold its value.
REQ-018 id_valid SHALL equal (count!=0), and id_pc/id_inst SHALL be the registered head entry.
- Latency: an instruction fetched in cycle N is visible at the head no earlier than cycle N+1.
REQ-019 A redirect SHALL override push and pop in the same cycle.
- count <= 0 and head/tail pointers <= 0.
- fetch PC <= {redirect_pc[31:2],2'b00}.
- No entry is written.
REQ-020 count SHALL be $clog2(DEPTH)+1 bits wide and head/tail pointers $clog2(DEPTH) bits wide; pointers wrap naturally modulo DEPTH.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, including when the queue is full and when it is at count=1.
REQ-022 Pop with count=0 SHALL be impossible (id_valid=0), and push with count=DEPTH and no pop SHALL be blocked; no entry is ever overwritten or lost.
REQ-023 id_pc/id_inst SHALL stay stable while id_valid=1 and id_ready=0.
REQ-024 icache_ready=0 SHALL stall fetching only; pops continue.

Reset
REQ-025 On reset the block SHALL set fetch PC=RESET_PC, count=0, head=tail=0, and id_valid=0.
- Consequently icache_addr=RESET_PC during and after reset.
REQ-026 Reset SHALL take priority over redirect, push and pop.
- Queue payload RAM is not cleared.
- Reset asserted mid-operation discards all queued entries at the next edge.

Structure
REQ-027 The shared constants package SHALL hold the data-width constant, RESET_PC default, and a packed fetch-entry typedef {pc[31:0], inst[31:0]}.
REQ-028 Queue storage with pointers and count SHALL be one sub-module, fetch_fifo, with push/pop/flush/full/empty; PC logic stays in inst_fetch_queue.

Verification
REQ-029 Reset release, icache_ready=1, id_ready=1, icache_inst=32'h0000_0013 -> icache_addr steps 1c00_0000, 1c00_0004, ...; id_valid rises one cycle after reset release with id_pc=32'h1c00_0000.
REQ-030 id_ready=0 for 6 cycles, icache_ready=1 -> exactly 4 pushes, then id_valid=1, count=4, icache_addr frozen at RESET_PC+16, head stable at 1c00_0000.
REQ-031 Full queue, then id_ready=1 and icache_ready=1 -> a push and a pop every cycle, count stays 4, PCs strictly consecutive, none lost or duplicated.
REQ-032 redirect_valid=1, redirect_pc=32'h1c00_0103 with id_ready=1 and 3 entries queued -> next cycle id_valid=0, icache_addr=32'h1c00_0100; following cycle id_pc=32'h1c00_0100.
REQ-033 Redirect to 32'hFFFF_FFFC, 2 fetches -> id_pc sequence FFFF_FFFC, 0000_0000.
REQ-034 Reset asserted with 3 entries queued and redirect_valid=1 in the same cycle -> next cycle id_valid=0, icache_addr=RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
package inst_fetch_queue_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    // One queued fetch: the address it was fetched from and the word returned.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Drop the byte offset so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Circular instruction queue: payload storage, head/tail pointers and count.
// Flush empties the queue without writing; reset does the same but wins.
module fetch_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_push_entry,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               w_do_push;
    logic               w_do_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == CNT_W'(0));
    assign o_head  = r_mem[r_head];

    // Qualify requests: never pop an empty queue, never push into a full one
    // unless the head leaves in the same cycle; flush suppresses both.
    always_comb begin
        w_do_pop  = 1'b0;
        w_do_push = 1'b0;
        if (i_flush) begin
            w_do_pop  = 1'b0;
            w_do_push = 1'b0;
        end else begin
            w_do_pop  = i_pop & ~o_empty;
            w_do_push = i_push & (~o_full | w_do_pop);
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= PTR_W'(0);
            r_tail  <= PTR_W'(0);
            r_count <= CNT_W'(0);
        end else if (i_flush) begin
            r_head  <= PTR_W'(0);
            r_tail  <= PTR_W'(0);
            r_count <= CNT_W'(0);
        end else begin
            if (w_do_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage is never cleared; only accepted pushes write it.
    always_ff @(posedge clk) begin
        if (!reset && w_do_push) begin
            r_mem[r_tail] <= i_push_entry;
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, drives the icache address,
// and buffers returned instructions in a small queue for decode.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] icache_addr,
    input  logic [31:0] icache_inst,
    input  logic        icache_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    input  logic        id_ready
);

    logic [31:0]  r_pc;
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_push;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    assign icache_addr = r_pc;
    assign id_valid    = ~w_empty;
    assign id_pc       = w_head.pc;
    assign id_inst     = w_head.inst;

    // Decide this cycle's queue traffic; a redirect cancels both directions
    // because everything queued and in flight is on the wrong path.
    always_comb begin
        w_pop             = 1'b0;
        w_push            = 1'b0;
        w_push_entry.pc   = r_pc;
        w_push_entry.inst = icache_inst;
        if (redirect_valid) begin
            w_pop  = 1'b0;
            w_push = 1'b0;
        end else begin
            w_pop  = id_valid & id_ready;
            w_push = icache_ready & (~w_full | w_pop);
        end
    end

    // Fetch PC: reset, then redirect, then advance by one word per push.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= word_align(RESET_PC);
        end else if (redirect_valid) begin
            r_pc <= word_align(redirect_pc);
        end else if (w_push) begin
            r_pc <= r_pc + 32'd4;
        end else begin
            r_pc <= r_pc;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_flush      (redirect_valid),
        .i_push_entry (w_push_entry),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios followed by random traffic,
// checked against a queue-based reference model through a negedge monitor.
module tb_inst_fetch_queue;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] icache_addr;
    logic [31:0] icache_inst;
    logic        icache_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .icache_addr    (icache_addr),
        .icache_inst    (icache_inst),
        .icache_ready   (icache_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_ready       (id_ready)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: scoreboard of {pc, inst} entries and the fetch PC.
    logic [63:0] sb[$];
    logic [31:0] mdl_pc   = RST_PC;
    bit          mdl_live = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each rising edge from the inputs presented to the DUT.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                sb.delete();
                mdl_pc   = RST_PC;
                mdl_live = 1'b1;
            end else if (redirect_valid) begin
                sb.delete();
                mdl_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                bit do_pop;
                bit do_push;
                do_pop  = (sb.size() != 0) && id_ready;
                do_push = icache_ready && ((sb.size() < DEPTH) || do_pop);
                if (do_pop) void'(sb.pop_front());
                if (do_push) begin
                    sb.push_back({mdl_pc, icache_inst});
                    mdl_pc = mdl_pc + 32'd4;
                end
            end
        end
    end

    // Monitor: compare the DUT outputs against the model between edges.
    initial begin
        forever begin
            @(negedge clk);
            if (mdl_live) begin
                chk("icache_addr", icache_addr, mdl_pc);
                chk("id_valid", {31'd0, id_valid}, {31'd0, (sb.size() != 0)});
                if (id_valid && sb.size() != 0) begin
                    chk("id_pc", id_pc, sb[0][63:32]);
                    chk("id_inst", id_inst, sb[0][31:0]);
                end
            end
        end
    end

    // Apply one cycle of inputs at a falling edge and wait for the next one.
    task automatic cyc(input logic rst, input logic rv, input logic [31:0] rpc,
                       input logic ir, input logic idr, input logic [31:0] inst);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        icache_ready   = ir;
        id_ready       = idr;
        icache_inst    = inst;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rpc;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
        icache_ready = 1'b0; id_ready = 1'b0; icache_inst = 32'd0;

        // Reset state
        cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_addr", icache_addr, RST_PC);

        // Streaming after reset release
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0013);
            chk("stream_addr", icache_addr, RST_PC + 32'(4 * (i + 1)));
            chk("stream_valid", {31'd0, id_valid}, 32'd1);
            chk("stream_pc", id_pc, RST_PC + 32'(4 * i));
            chk("stream_inst", id_inst, 32'h0000_0013);
        end

        // Fill with decode stalled: exactly DEPTH pushes
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, $urandom);
        chk("full_addr", icache_addr, RST_PC + 32'd16);
        chk("full_head", id_pc, RST_PC);
        chk("full_valid", {31'd0, id_valid}, 32'd1);

        // Full queue with push and pop every cycle
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, $urandom);
            chk("pp_addr", icache_addr, RST_PC + 32'd16 + 32'(4 * (i + 1)));
            chk("pp_head", id_pc, RST_PC + 32'(4 * (i + 1)));
        end

        // Redirect with three entries queued and decode ready
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, $urandom);
        cyc(1'b0, 1'b1, 32'h1c00_0103, 1'b1, 1'b1, $urandom);
        chk("redir_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_addr", icache_addr, 32'h1c00_0100);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, $urandom);
        chk("redir_head", id_pc, 32'h1c00_0100);

        // Redirect to the top of the address space and wrap
        cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, $urandom);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, $urandom);
        chk("wrap_head0", id_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", icache_addr, 32'h0000_0004);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0);
        chk("wrap_head1", id_pc, 32'h0000_0000);

        // Reset and redirect together with three entries queued
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, $urandom);
        cyc(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1, $urandom);
        chk("rst_redir_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_redir_addr", icache_addr, RST_PC);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'h0000_000F);
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 15) == 0),
                rpc,
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) != 0),
                $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
